// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit accumulator CPU.
// Opcode and sequencer phase encodings.
package cpu_pkg;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } state_t;

  function automatic logic is_aluop(opcode_t op);
    return (op == ADD) || (op == AND) ||
           (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/sequence_ctrl.sv
// Eight-phase instruction sequencer.
// Drives datapath enables and memory strobes.
module sequence_ctrl
  import cpu_pkg::*;
#(
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output logic           mem_rd,
  output logic           mem_wr,
  output logic           load_ir,
  output logic           load_ac,
  output logic           load_pc,
  output logic           inc_pc,
  output logic           halt
);

  state_t  state_q;
  state_t  state_d;
  opcode_t op;
  logic    alu;

  assign op  = opcode_t'(opcode);
  assign alu = is_aluop(op);

  // HLT parks the sequencer in OP_ADDR until reset
  always_comb begin
    state_d = state_t'(state_q + 3'd1);
    if (state_q == OP_ADDR && op == HLT)
      state_d = OP_ADDR;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= INST_ADDR;
    else     state_q <= state_d;
  end

  always_comb begin
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    load_ir = 1'b0;
    load_ac = 1'b0;
    load_pc = 1'b0;
    inc_pc  = 1'b0;
    halt    = 1'b0;
    unique case (state_q)
      INST_ADDR: ;
      INST_FETCH: begin
        mem_rd = 1'b1;
      end
      INST_LOAD, IDLE: begin
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      OP_ADDR: begin
        halt   = (op == HLT);
        inc_pc = (op != HLT);
      end
      OP_FETCH: begin
        mem_rd = alu;
      end
      ALU_OP: begin
        mem_rd  = alu;
        load_ac = alu;
        inc_pc  = (op == SKZ) && zero;
        load_pc = (op == JMP);
      end
      STORE: begin
        mem_rd  = alu;
        load_ac = alu;
        load_pc = (op == JMP);
        mem_wr  = (op == STO);
      end
    endcase
  end

endmodule
